// File: rtl/axi_slave_pkg.sv
// Shared types and constants for the AXI slave core.
// Optional build macro used by the core: AXI_WRESP_SLVERR_EN.
package axi_slave_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {WR_IDLE, WR_RESP} wresp_state_t;

endpackage

// File: rtl/axi_wresp_fifo.sv
// Synchronous FIFO with occupancy count; used for the AW id queue and the
// completed-burst queue of the write-response scheduler.
module axi_wresp_fifo
   import axi_slave_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // DEPTH is a power of two, so the pointers wrap naturally
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == FULL_COUNT);
   assign empty = (count == '0);

endmodule

// File: rtl/axi_wresp_sched.sv
// AXI write-response scheduler: pairs AW ids with completed W bursts in order
// and drives the B channel. Define AXI_WRESP_SLVERR_EN to report SLVERR.
module axi_wresp_sched
   import axi_slave_pkg::*;
#(
   parameter int ID_W  = 6,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            aw_push,
   input  logic [ID_W-1:0] aw_id,
   output logic            aw_full,
   input  logic            w_beat,
   input  logic            w_last,
   input  logic            w_err,
   output logic            w_full,
   input  logic            BREADY,
   output logic            BVALID,
   output logic [ID_W-1:0] BID,
   output logic [1:0]      BRESP
);

   localparam int CW = $clog2(DEPTH) + 1;

   wresp_state_t    state;
   wresp_state_t    next_state;
   logic            load;
   logic            pop;
   logic [ID_W-1:0] aw_head;
   logic [CW-1:0]   aw_count;
   logic            aw_empty;
   logic            wl_push;
   logic            wl_empty;
   logic            unused;

   assign wl_push = w_beat && w_last;

   axi_wresp_fifo #(.WIDTH(ID_W), .DEPTH(DEPTH)) u_aw_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (aw_push),
      .push_data (aw_id),
      .pop       (pop),
      .head      (aw_head),
      .count     (aw_count),
      .full      (aw_full),
      .empty     (aw_empty)
   );

`ifdef AXI_WRESP_SLVERR_EN
   logic          err_acc;
   logic          wl_flag;
   logic          wl_head;
   logic [CW-1:0] wl_count;

   // the last beat's own error counts toward the burst it closes
   assign wl_flag = err_acc | w_err;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_acc <= 1'b0;
      end else if (w_beat) begin
         err_acc <= w_last ? 1'b0 : (err_acc | w_err);
      end
   end

   axi_wresp_fifo #(.WIDTH(1), .DEPTH(DEPTH)) u_wl_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (wl_push),
      .push_data (wl_flag),
      .pop       (pop),
      .head      (wl_head),
      .count     (wl_count),
      .full      (w_full),
      .empty     (wl_empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         BRESP <= RESP_OKAY;
      end else if (load) begin
         BRESP <= wl_head ? RESP_SLVERR : RESP_OKAY;
      end
   end

   assign unused = ^{aw_count, wl_count};
`else
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [CW-1:0] wl_count;
   logic          wl_push_ok;
   logic          wl_pop_ok;

   // without error reporting only the number of completed bursts matters
   assign wl_push_ok = wl_push && !w_full;
   assign wl_pop_ok  = pop && !wl_empty;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wl_count <= '0;
      end else begin
         case ({wl_push_ok, wl_pop_ok})
            2'b10:   wl_count <= wl_count + CW'(1);
            2'b01:   wl_count <= wl_count - CW'(1);
            default: wl_count <= wl_count;
         endcase
      end
   end

   assign w_full   = (wl_count == FULL_COUNT);
   assign wl_empty = (wl_count == '0);
   assign BRESP    = RESP_OKAY;
   assign unused   = ^{aw_count, w_err};
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= WR_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // RESP always drops back through IDLE, so heads are stable while BVALID is up
   always_comb begin
      next_state = state;
      load       = 1'b0;
      pop        = 1'b0;
      case (state)
         WR_IDLE: begin
            if (!aw_empty && !wl_empty) begin
               next_state = WR_RESP;
               load       = 1'b1;
            end
         end
         WR_RESP: begin
            if (BREADY) begin
               next_state = WR_IDLE;
               pop        = 1'b1;
            end
         end
         default: next_state = WR_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         BID <= '0;
      end else if (load) begin
         BID <= aw_head;
      end
   end

   assign BVALID = (state == WR_RESP);

endmodule

// File: doc/axi_wresp_sched.md
# axi_wresp_sched

Write-response scheduler for the AXI slave core. It pairs accepted AW addresses with completed W bursts in order, and drives the B channel with a compliant VALID/READY handshake. BVALID is held until BREADY is seen. It replaces free-running BVALID generation and sits between the AW/W acceptance logic and the B output port.

## Interface
Parameters:
- ID_W, 6, AXI ID width.
- DEPTH, 4, maximum outstanding AW entries and completed-W entries (power of two, ≥2).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- aw_push  in  1  AW handshake this cycle (AWVALID && AWREADY).
- aw_id  in  ID_W  AWID sampled on aw_push.
- aw_full  out  1  AW queue full; upstream gates AWREADY with it.
- w_beat  in  1  W handshake this cycle (WVALID && WREADY).
- w_last  in  1  WLAST qualified by w_beat.
- w_err  in  1  slave error on this beat (used only with AXI_WRESP_SLVERR_EN).
- w_full  out  1  completed-burst queue full; upstream gates WREADY with it.
- BREADY  in  1  master ready.
- BVALID  out  1  response valid.
- BID  out  ID_W  response ID.
- BRESP  out  2  2'b00 OKAY, 2'b10 SLVERR.

## Operation
- AW queue: a DEPTH-entry FIFO of IDs. It is pushed on aw_push when not full. A push while full is dropped.
- WL queue: a DEPTH-entry FIFO of 1-bit error flags. It is pushed on w_beat && w_last when not full.
  - The pushed flag is the OR of w_err over all beats of the burst, including the last beat.
  - An internal sticky err_acc clears after each push.
- AW and W may arrive in any relative order. Pairing is strictly FIFO order, as AXI4 has no WID.
- State machine, two states:
  - IDLE → RESP when both queues are non-empty. On that edge it registers BID = AW head, BRESP from WL head flag, and BVALID = 1.
  - RESP holds BVALID, BID and BRESP stable while BREADY = 0.
  - RESP → IDLE on BREADY = 1. Both queues are popped on that edge and BVALID clears.
- A push and a pop on the same queue in the same cycle are both honoured, and the count is unchanged.
- aw_full and w_full are combinational from the counts. They go high exactly when count == DEPTH.
- Pointers wrap modulo DEPTH. Counts are $clog2(DEPTH)+1 bits wide.

## Timing
- Reset values: BVALID 0, BID 0, BRESP 2'b00, aw_full 0, w_full 0. State is IDLE, counts and pointers are 0, err_acc is 0.
- Reset asserted mid-handshake (RESP) clears BVALID immediately and discards both queues.
- Latency: BVALID rises 1 cycle after the edge on which the second of the two queues becomes non-empty.
- Throughput: at most one response per 2 cycles, because RESP always returns through IDLE.
- Head entries must not change while in RESP. Pops only occur on the RESP → IDLE edge.

## Configuration
- AXI_WRESP_SLVERR_EN defined:
  - w_err is accumulated per burst.
  - BRESP = 2'b10 for a burst with any errored beat, 2'b00 otherwise.
- Not defined:
  - w_err is ignored.
  - WL queue flag storage is removed, leaving only a counter.
  - BRESP is constant 2'b00.

## Structure
- Shared package axi_slave_pkg:
  - RESP_OKAY and RESP_SLVERR constants.
  - State enum wresp_state_t {WR_IDLE, WR_RESP}.
- Sub-module axi_wresp_fifo: parameterised synchronous FIFO (WIDTH, DEPTH) with count, full and empty outputs. It is instantiated for the AW queue (WIDTH = ID_W) and the WL queue (WIDTH = 1).

## Test plan
- Single write: AW id 6'h0A, then a 4-beat W with last on beat 4, BREADY = 1. Expected: BVALID for exactly 1 cycle, starting 1 cycle after the last beat, with BID 6'h0A and BRESP 2'b00.
- W before AW: a 1-beat burst completes, and AW id 6'h15 arrives 5 cycles later. Expected: BVALID is 0 until the cycle after aw_push, then BID 6'h15.
- Backpressure: BREADY held 0 for 10 cycles. Expected: BVALID, BID and BRESP stay stable for all 10 cycles, and the pop occurs on the first BREADY = 1 edge.
- Full: push 4 AW IDs 1..4 with no W. Expected: aw_full = 1 and a 5th push is dropped. Completing 4 bursts then yields BIDs 1, 2, 3, 4 in order.
- Error (macro on): 3-beat burst with w_err on beat 2. Expected: BRESP 2'b10. The next clean burst gives BRESP 2'b00.
- Reset while BVALID = 1 and BREADY = 0. Expected: BVALID falls asynchronously, both queues are empty after reset, and no stale response appears.
